// File: rtl/vc_fifo_pkg.sv
// Shared sizing defaults for the demux, the main FIFO and the per-VC FIFOs.
package vc_fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 5;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int THR_HIGH_DEF    = FIFO_DEPTH - 2;
  localparam int THR_LOW_DEF     = FIFO_DEPTH / 4;
endpackage

// File: rtl/vc_fifo_if.sv
// Demux-side and downstream-side signals of one virtual-channel FIFO.
interface vc_fifo_if import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();
  // Handshake: push/pop are single-cycle requests with no ready signal. A push
  // lands unless the FIFO is full with no simultaneous pop; a pop lands only when
  // count > 0. Rejected requests set the sticky error. Flow control upstream is
  // the registered pause, which leaves room for one in-flight push.
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [ADDR_WIDTH:0]   thr_high;
  logic [ADDR_WIDTH:0]   thr_low;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  pause;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, data_in, pop, thr_high, thr_low,
    input  data_out, valid_out, pause, full, empty, count, error
  );

  modport slave (
    input  push, data_in, pop, thr_high, thr_low,
    output data_out, valid_out, pause, full, empty, count, error
  );
endinterface

// File: rtl/vc_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one synchronous read
// port whose output holds between reads. No reset on the array or read register.
module fifo_ram import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-address write this edge is not seen by this read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/vc_fifo.sv
// Per-VC FIFO: circular pointers, occupancy count, hysteretic pause, sticky error.
// Storage lives in fifo_ram; read data appears one cycle after an accepted pop.
module vc_fifo import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  vc_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH:0]   thr_high_r;
  logic [ADDR_WIDTH:0]   thr_low_r;
  logic                  pause_r;
  logic                  pause_next;
  logic                  error_r;
  logic                  valid_r;
  logic                  out_zero_r;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  bad_req;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  always_comb begin
    pop_ok     = bus.pop && (count_r != '0);
    push_ok    = bus.push && ((count_r != FULL_COUNT) || pop_ok);
    bad_req    = (bus.push && !push_ok) || (bus.pop && !pop_ok);
    count_next = count_r;
    if (push_ok && !pop_ok) count_next = count_r + ONE;
    else if (pop_ok && !push_ok) count_next = count_r - ONE;
    pause_next = pause_r;
    if (count_next >= thr_high_r) pause_next = 1'b1;
    else if (count_next <= thr_low_r) pause_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      pause_r    <= 1'b0;
      error_r    <= 1'b0;
      out_zero_r <= 1'b1;
      thr_high_r <= bus.thr_high;
      thr_low_r  <= bus.thr_low;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (pop_ok) out_zero_r <= 1'b0;
      if (bad_req) error_r <= 1'b1;
      count_r <= count_next;
      valid_r <= pop_ok;
      pause_r <= pause_next;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok && !reset),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (pop_ok && !reset),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset, so data_out reads as zero until the
  // first pop after reset; afterwards it tracks the RAM register, which holds.
  assign bus.data_out  = out_zero_r ? '0 : ram_rd_data;
  assign bus.valid_out = valid_r;
  assign bus.pause     = pause_r;
  assign bus.error     = error_r;
  assign bus.count     = count_r;
  assign bus.full      = (count_r == FULL_COUNT);
  assign bus.empty     = (count_r == '0);
endmodule
